// File: rtl/icache.sv
// ============================================================================
// Module   : icache
// Brief    : Direct-mapped, read-only instruction cache with single line fill.
//            Optional hit/miss counters when ICACHE_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache #(
    parameter int LINE_BYTES = 16,
    parameter int NUM_LINES  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    clear,
    input  logic                    fetch_en,
    input  logic [31:0]             fetch_pc,
    output logic                    inst_valid,
    output logic [31:0]             inst,
    output logic                    mem_if_en,
    output logic [31:0]             mem_if_pc,
`ifdef ICACHE_PERF_EN
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt,
`endif
    input  logic                    mem_if_done,
    input  logic [8*LINE_BYTES-1:0] mem_if_data
);

    localparam int c_OFF_W  = $clog2(LINE_BYTES);
    localparam int c_IDX_W  = $clog2(NUM_LINES);
    localparam int c_TAG_W  = 32 - c_OFF_W - c_IDX_W;
    localparam int c_WORDS  = LINE_BYTES / 4;
    localparam int c_WSEL_W = (c_OFF_W > 2) ? (c_OFF_W - 2) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MISS = 1'b1
    } state_t;

    state_t                      r_state;
    logic [NUM_LINES-1:0]        r_valid;
    logic [c_TAG_W-1:0]          r_tag  [NUM_LINES];
    logic [c_WORDS-1:0][31:0]    r_data [NUM_LINES];
    logic [31:0]                 r_pc;
    logic                        r_drop;
    logic                        r_inst_valid;
    logic [31:0]                 r_inst;
    logic                        r_mem_if_en;
    logic [31:0]                 r_mem_if_pc;

    logic [c_IDX_W-1:0]          w_fetch_idx;
    logic [c_TAG_W-1:0]          w_fetch_tag;
    logic [c_WSEL_W-1:0]         w_fetch_wsel;
    logic [c_IDX_W-1:0]          w_miss_idx;
    logic [c_TAG_W-1:0]          w_miss_tag;
    logic [c_WSEL_W-1:0]         w_miss_wsel;
    logic [c_WORDS-1:0][31:0]    w_fill_words;
    logic                        w_hit;
    logic                        w_accept;
    logic                        w_fill;
    logic                        w_unused_bits;

    assign w_fetch_idx  = fetch_pc[c_OFF_W +: c_IDX_W];
    assign w_fetch_tag  = fetch_pc[31 -: c_TAG_W];
    assign w_miss_idx   = r_pc[c_OFF_W +: c_IDX_W];
    assign w_miss_tag   = r_pc[31 -: c_TAG_W];
    assign w_fill_words = mem_if_data;
    assign w_unused_bits = ^{fetch_pc[1:0], r_pc[1:0]};

    generate
        if (c_OFF_W > 2) begin : g_wsel
            assign w_fetch_wsel = fetch_pc[c_OFF_W-1:2];
            assign w_miss_wsel  = r_pc[c_OFF_W-1:2];
        end else begin : g_wsel_single
            assign w_fetch_wsel = '0;
            assign w_miss_wsel  = '0;
        end
    endgenerate

    assign w_hit    = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
    assign w_accept = rdy && (r_state == S_IDLE) && fetch_en && !clear;
    assign w_fill   = rdy && (r_state == S_MISS) && mem_if_done;

    // The response register is held while rdy is low so it can be re-presented;
    // clear squashes whatever response is currently showing.
    assign inst_valid = r_inst_valid && rdy && !clear;
    assign inst       = r_inst;
    assign mem_if_en  = r_mem_if_en;
    assign mem_if_pc  = r_mem_if_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_pc         <= '0;
            r_drop       <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_mem_if_en  <= 1'b0;
            r_mem_if_pc  <= '0;
        end else if (rdy) begin
            case (r_state)
                S_IDLE: begin
                    r_inst_valid <= 1'b0;
                    if (w_accept) begin
                        r_pc <= fetch_pc;
                        if (w_hit) begin
                            r_inst_valid <= 1'b1;
                            r_inst       <= r_data[w_fetch_idx][w_fetch_wsel];
                        end else begin
                            r_state     <= S_MISS;
                            r_mem_if_en <= 1'b1;
                            r_mem_if_pc <= {fetch_pc[31:c_OFF_W], {c_OFF_W{1'b0}}};
                        end
                    end
                end
                S_MISS: begin
                    if (mem_if_done) begin
                        r_valid[w_miss_idx] <= 1'b1;
                        r_mem_if_en         <= 1'b0;
                        r_inst_valid        <= !(r_drop || clear);
                        r_inst              <= w_fill_words[w_miss_wsel];
                        r_drop              <= 1'b0;
                        r_state             <= S_IDLE;
                    end else if (clear) begin
                        r_drop <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag and data storage need no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_miss_idx]  <= w_miss_tag;
            r_data[w_miss_idx] <= w_fill_words;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_accept) begin
            if (w_hit) begin
                if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the fetch unit and the memory controller. Serves 32-bit instruction reads from fetch; on a miss, issues one line-fill request on the controller's instruction-fetch port (`if_en`/`if_pc`/`if_done`/`if_data`), installs the returned line and forwards the requested word. Read-only; no coherence with stores (self-modifying code unsupported).

## Interface

Parameters:
- `LINE_BYTES`, 16: bytes per line; equals `MEM_CTRL_IF_DATA_LEN`; power of 2, ≥4.
- `NUM_LINES`, 16: number of lines; power of 2.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `rdy` in 1: global ready; low freezes the block.
- `clear` in 1: pipeline flush; drops the pending request.
- `fetch_en` in 1: one-cycle request strobe.
- `fetch_pc` in 32: request address; bits [1:0] ignored.
- `inst_valid` out 1: one-cycle response strobe.
- `inst` out 32: instruction word, little-endian.
- `mem_if_en` out 1: line-fill request to the memory controller.
- `mem_if_pc` out 32: line-aligned fill address.
- `mem_if_done` in 1: one-cycle fill-complete pulse.
- `mem_if_data` in 8·LINE_BYTES: line data; byte i at bits [8i+7:8i].

## Operation

- Address split: offset = log2(LINE_BYTES) bits; index = the next log2(NUM_LINES) bits; tag = the remaining upper bits.
- Storage per line: valid bit, tag, data.
- States:
  - `IDLE` — request accepted when `fetch_en && !clear`. pc is latched.
    - Hit: `inst_valid`=1 next cycle, carrying the word at pc[offset] from the line; stay `IDLE`.
    - Miss: → `MISS` and drive `mem_if_en`=1, `mem_if_pc`={pc[31:off], 0}.
  - `MISS` — hold `mem_if_en`/`mem_if_pc` constant until `mem_if_done`. On `mem_if_done`:
    - Write the line; set the valid bit; store the tag.
    - Deassert `mem_if_en` (registered, so low the next cycle).
    - If not dropped: `inst_valid`=1 next cycle with the word taken from `mem_if_data` (not from the array).
    - → `IDLE`.
- `fetch_en` in `MISS`: ignored; the fetch unit must not issue it.
- A new request is legal in the same cycle `inst_valid` is high, so back-to-back hits sustain one instruction per cycle.
- `clear`:
  - In `IDLE`: suppresses acceptance that cycle. `clear` beats a simultaneous `fetch_en`.
  - Any hit response already registered for the next cycle is squashed (`inst_valid`=0).
  - In `MISS`: sets the drop flag. The fill still completes, because the controller cannot abort, and the line is installed. No `inst_valid`. Then → `IDLE`.
- `rdy` low: no state, array or output register changes, except `inst_valid` forced to 0. A pending response is re-presented once `rdy` returns.

## Timing

- Reset values: `inst_valid`=0, `inst`=0, `mem_if_en`=0, `mem_if_pc`=0, state `IDLE`, all valid bits 0, drop flag 0.
- Reset in `MISS` abandons the fill; the block ignores a later `mem_if_done` while in `IDLE`.
- Hit latency: 1 cycle (request at edge n, `inst_valid` high after edge n+1).
- Miss latency: controller fill time + 1. `inst_valid` rises the cycle after `mem_if_done`.
- `mem_if_en` is low in the cycle after `mem_if_done`. The controller ignores requests while its done is high, so no duplicate fill is possible.
- Index aliasing: a fill overwrites the resident line unconditionally.
- pc wrap: address 0xFFFFFFFC maps normally; no special case.

## Configuration

- `ICACHE_PERF_EN` defined:
  - Adds outputs `hit_cnt` and `miss_cnt` (32 bits each).
  - Counted per accepted request; each saturates at 0xFFFFFFFF.
  - Requests suppressed by `clear` are not counted.
  - Reset to 0.
- `ICACHE_PERF_EN` undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan

- Cold miss: reset, request pc=0x1008 → `mem_if_en`=1 with `mem_if_pc`=0x1000. Drive a done pulse with bytes 0x00..0x0F → `inst`=0x0B0A0908 one cycle later, `inst_valid` high for exactly one cycle.
- Hits: after the fill, request 0x1000, 0x1004, 0x100C on consecutive cycles → 0x03020100, 0x07060504, 0x0F0E0D0C on three consecutive cycles, `mem_if_en` stays 0.
- Conflict: fill 0x1000, then request 0x1100 (same index, NUM_LINES=16) → miss with fill at 0x1100. A subsequent request to 0x1000 misses again.
- Clear during miss: request 0x2000, assert `clear` mid-fill → no `inst_valid`. A later request to 0x2004 hits with 1-cycle latency.
- Clear wins: `fetch_en` and `clear` asserted together on a hit address → no `inst_valid`, state `IDLE`.
- `rdy` stall: drop `rdy` for 3 cycles in the cycle a hit would respond → `inst_valid` low throughout, then a one-cycle pulse with the correct word after `rdy` rises. With `ICACHE_PERF_EN`, `hit_cnt` increments by 1.
